pipeline_stall_ctrl: RTL and testbench

//  Parametrised stall/bubble/flush controller for an N-stage in-order pipeline (stage 0 = fetch, N-1 = writeback).

---
 rtl/stall_ctrl_pkg.sv | 24 ++
 rtl/stall_ctrl_mc_timer.sv | 75 +++++++
 rtl/pipeline_stall_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - shared stage indices, multi-cycle FSM states and width helpers
package stall_ctrl_pkg;

  // Canonical stage indices of the 5-stage in-order pipeline
  typedef enum int {
    STG_FETCH  = 0,
    STG_DECODE = 1,
    STG_EXEC   = 2,
    STG_MEM    = 3,
    STG_WB     = 4
  } stage_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  // Counter width able to hold values 0..value-1, never narrower than one bit
  function automatic int clog2_min1(input int value);
    clog2_min1 = (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/stall_ctrl_mc_timer.sv
// rtl/stall_ctrl_mc_timer.sv - multi-cycle op FSM holding the host stage for a run-time latency
module stall_ctrl_mc_timer
  import stall_ctrl_pkg::*;
#(
  parameter int LAT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [LAT_W-1:0] i_lat,
  input  logic             i_adv,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done
);

  mc_state_e        r_state;
  mc_state_e        w_state_nxt;
  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] w_cnt_nxt;

  // State and remaining-cycle counter registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter update and status outputs; a kill of the host stage aborts from anywhere
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Latency 0/1 completes in the entry cycle, so no internal stall is needed
        if (i_start && i_adv && (i_lat > LAT_W'(1))) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = i_lat - LAT_W'(2);
        end
      end
      BUSY: begin
        o_busy = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - LAT_W'(1);
        end
      end
      DONE: begin
        o_done = 1'b1;
        if (i_adv) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (i_abort) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end
  end

  // A new multi-cycle op must not arrive while the previous one still occupies the stage
  a_no_start_when_occupied: assert property (@(posedge i_clk) disable iff (i_reset)
    !(i_start && (r_state != IDLE)));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/bubble/kill controller; PIPELINE_STALL_CTRL_PERF_EN adds perf counters
module pipeline_stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int NUM_STAGES    = 5,
  parameter int MC_STAGE      = int'(STG_EXEC),
  parameter int LAT_W         = 4,
  parameter int REDIRECT_HOLD = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NUM_STAGES-1:0]       i_stall_req,
  input  logic [NUM_STAGES-1:0]       i_flush_req,
  input  logic                        i_exc_req,
  input  logic                        i_mc_start,
  input  logic [LAT_W-1:0]            i_mc_lat,
  output logic [NUM_STAGES-1:0]       o_stall,
  output logic [NUM_STAGES-1:0]       o_bubble,
  output logic [NUM_STAGES-1:0]       o_kill,
  output logic                        o_mc_busy,
  output logic                        o_mc_done,
  output logic                        o_redirect_hold,
  input  logic [$clog2(NUM_STAGES):0] i_perf_sel,
  output logic [31:0]                 o_perf_cnt
);

  localparam int RH_W = clog2_min1(REDIRECT_HOLD + 1);

  logic [NUM_STAGES-1:0] w_stall_c;
  logic [NUM_STAGES-1:0] w_kill;
  logic [NUM_STAGES-1:0] w_bubble;
  logic [NUM_STAGES-1:0] w_stall;
  logic                  w_mc_busy;
  logic                  w_rh;
  logic [RH_W-1:0]       r_rh_cnt;

  // Backward stall chain, oldest-wins kill mask and NOP insertion, all same-cycle
  always_comb begin
    w_stall_c = '0;
    w_kill    = '0;
    w_bubble  = '0;
    w_stall_c[NUM_STAGES-1] = i_stall_req[NUM_STAGES-1] | ((MC_STAGE == NUM_STAGES-1) & w_mc_busy);
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      w_stall_c[i] = i_stall_req[i] | ((MC_STAGE == i) & w_mc_busy) | w_stall_c[i+1];
    end
    // A stalled stage cannot redirect: its branch has not resolved into a committed outcome yet
    w_kill[NUM_STAGES-1] = i_exc_req;
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      w_kill[i] = w_kill[i+1] | (i_flush_req[i+1] & ~w_stall_c[i+1]);
    end
    w_bubble[0] = w_kill[0] | w_rh;
    for (int i = 1; i < NUM_STAGES; i++) begin
      w_bubble[i] = w_kill[i] | (w_stall_c[i-1] & ~w_stall_c[i]);
    end
  end

  assign w_stall         = w_stall_c & ~w_kill;
  assign o_stall         = i_reset ? '0 : w_stall;
  assign o_bubble        = i_reset ? '1 : w_bubble;
  assign o_kill          = i_reset ? '0 : w_kill;
  assign w_rh            = (r_rh_cnt != '0);
  assign o_redirect_hold = w_rh;
  assign o_mc_busy       = w_mc_busy;

  stall_ctrl_mc_timer #(
    .LAT_W (LAT_W)
  ) u_mc_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_mc_start),
    .i_lat   (i_mc_lat),
    .i_adv   (~w_stall_c[MC_STAGE]),
    .i_abort (w_kill[MC_STAGE]),
    .o_busy  (w_mc_busy),
    .o_done  (o_mc_done)
  );

  // Post-kill fetch bubble window; a new kill reloads rather than extends
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rh_cnt <= '0;
    end else if (w_kill[0]) begin
      r_rh_cnt <= RH_W'(REDIRECT_HOLD);
    end else if (r_rh_cnt != '0) begin
      r_rh_cnt <= r_rh_cnt - RH_W'(1);
    end
  end

`ifdef PIPELINE_STALL_CTRL_PERF_EN
  localparam int PS_W = $clog2(NUM_STAGES) + 1;

  logic [31:0] r_perf_stall [NUM_STAGES];
  logic [31:0] r_perf_kill;

  // Free-running wrapping counters of stall cycles per stage and of kill events
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        r_perf_stall[i] <= '0;
      end
      r_perf_kill <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (w_stall[i]) begin
          r_perf_stall[i] <= r_perf_stall[i] + 32'd1;
        end
      end
      if (|w_kill) begin
        r_perf_kill <= r_perf_kill + 32'd1;
      end
    end
  end

  // Counter read mux: stage counters first, kill counter right after, zero beyond
  always_comb begin
    o_perf_cnt = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i_perf_sel == PS_W'(i)) begin
        o_perf_cnt = r_perf_stall[i];
      end
    end
    if (i_perf_sel == PS_W'(NUM_STAGES)) begin
      o_perf_cnt = r_perf_kill;
    end
  end
`else
  logic w_unused_perf_sel;

  assign w_unused_perf_sel = ^i_perf_sel;
  assign o_perf_cnt        = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed scoreboard bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

  localparam int N    = 5;
  localparam int PS_W = $clog2(N) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    stall_req, flush_req;
  logic            exc_req, mc_start;
  logic [3:0]      mc_lat;
  logic [N-1:0]    stall, bubble, kill;
  logic            mc_busy, mc_done, rh;
  logic [PS_W-1:0] perf_sel;
  logic [31:0]     perf_cnt;

  typedef struct {
    string        tag;
    logic [N-1:0] stall;
    logic [N-1:0] bubble;
    logic [N-1:0] kill;
    logic         busy;
    logic         done;
    logic         rh;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .NUM_STAGES    (N),
    .MC_STAGE      (2),
    .LAT_W         (4),
    .REDIRECT_HOLD (2)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_stall_req     (stall_req),
    .i_flush_req     (flush_req),
    .i_exc_req       (exc_req),
    .i_mc_start      (mc_start),
    .i_mc_lat        (mc_lat),
    .o_stall         (stall),
    .o_bubble        (bubble),
    .o_kill          (kill),
    .o_mc_busy       (mc_busy),
    .o_mc_done       (mc_done),
    .o_redirect_hold (rh),
    .i_perf_sel      (perf_sel),
    .o_perf_cnt      (perf_cnt)
  );

  task automatic check_one(input string tag, input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [N-1:0] sr, input logic [N-1:0] fr,
                      input logic exc, input logic st, input logic [3:0] lat,
                      input logic [N-1:0] e_s, input logic [N-1:0] e_b, input logic [N-1:0] e_k,
                      input logic e_busy, input logic e_done, input logic e_rh);
    exp_t e;
    exp_t got;
    stall_req = sr;
    flush_req = fr;
    exc_req   = exc;
    mc_start  = st;
    mc_lat    = lat;
    e.tag = tag; e.stall = e_s; e.bubble = e_b; e.kill = e_k;
    e.busy = e_busy; e.done = e_done; e.rh = e_rh;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      got = sb_q.pop_front();
      check_one(got.tag, "stall",   32'(stall),   32'(got.stall));
      check_one(got.tag, "bubble",  32'(bubble),  32'(got.bubble));
      check_one(got.tag, "kill",    32'(kill),    32'(got.kill));
      check_one(got.tag, "mc_busy", 32'(mc_busy), 32'(got.busy));
      check_one(got.tag, "mc_done", 32'(mc_done), 32'(got.done));
      check_one(got.tag, "rh",      32'(rh),      32'(got.rh));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic perf_chk(input string tag, input logic [PS_W-1:0] sel, input logic [31:0] exp);
    perf_sel = sel;
    #1;
    check_one(tag, "perf_cnt", perf_cnt, exp);
  endtask

  initial begin
    rst = 1'b1; stall_req = '0; flush_req = '0; exc_req = 1'b0;
    mc_start = 1'b0; mc_lat = '0; perf_sel = '0;
    @(posedge clk);
    #1;
    // reset forces stall=0, bubble=all 1, kill=0 regardless of requests
    step("rst_idle", 5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b11111, 5'b00000, 0, 0, 0);
    step("rst_reqs", 5'b01000, 5'b00100, 1, 0, 4'd0, 5'b00000, 5'b11111, 5'b00000, 0, 0, 0);
    rst = 1'b0;
    step("idle",     5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    // multi-cycle op, latency 4: three busy cycles then one done cycle
    step("mc4_start", 5'b00000, 5'b00000, 0, 1, 4'd4, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("mc4_busy", 5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00111, 5'b01000, 5'b00000, 1, 0, 0);
    end
    step("mc4_done", 5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0);
    step("mc4_idle", 5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
`ifdef PIPELINE_STALL_CTRL_PERF_EN
    perf_chk("perf_stg0", 4'd0, 32'd3);
    perf_chk("perf_stg2", 4'd2, 32'd3);
    perf_chk("perf_stg3", 4'd3, 32'd0);
    perf_chk("perf_sel7", 4'd7, 32'd0);
`else
    perf_chk("perf_off", 4'd5, 32'd0);
`endif
    perf_sel = '0;
    @(posedge clk);
    #1;
    // single-cycle downstream stall
    step("t1_stall3", 5'b01000, 5'b00000, 0, 0, 4'd0, 5'b01111, 5'b10000, 5'b00000, 0, 0, 0);
    step("t1_free",   5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    // redirect from stage 2 then two forced fetch bubbles
    step("t3_flush2", 5'b00000, 5'b00100, 0, 0, 4'd0, 5'b00000, 5'b00011, 5'b00011, 0, 0, 0);
    step("t3_hold1",  5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00001, 5'b00000, 0, 0, 1);
    step("t3_hold2",  5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00001, 5'b00000, 0, 0, 1);
    step("t3_clear",  5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    // re-kill inside the window reloads the hold counter
    step("rk_flush2", 5'b00000, 5'b00100, 0, 0, 4'd0, 5'b00000, 5'b00011, 5'b00011, 0, 0, 0);
    step("rk_flush1", 5'b00000, 5'b00010, 0, 0, 4'd0, 5'b00000, 5'b00001, 5'b00001, 0, 0, 1);
    step("rk_hold_a", 5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00001, 5'b00000, 0, 0, 1);
    step("rk_hold_b", 5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00001, 5'b00000, 0, 0, 1);
    step("rk_clear",  5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    // flush from a stalled stage is ignored
    step("t4_flush_stl", 5'b01000, 5'b00100, 0, 0, 4'd0, 5'b01111, 5'b10000, 5'b00000, 0, 0, 0);
    step("t4_after",     5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    // latency 1 adds no stall; a start while the stage is stalled is not accepted
    step("lat1_start", 5'b00000, 5'b00000, 0, 1, 4'd1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    step("lat1_after", 5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    step("blk_start",  5'b01000, 5'b00000, 0, 1, 4'd4, 5'b01111, 5'b10000, 5'b00000, 0, 0, 0);
    step("blk_after",  5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    // latency 2: one busy cycle, done held while downstream stalls
    step("l2_start",  5'b00000, 5'b00000, 0, 1, 4'd2, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    step("l2_busy",   5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00111, 5'b01000, 5'b00000, 1, 0, 0);
    step("l2_held",   5'b01000, 5'b00000, 0, 0, 4'd0, 5'b01111, 5'b10000, 5'b00000, 0, 1, 0);
    step("l2_adv",    5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0);
    step("l2_idle",   5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    // exception while busy with two cycles left aborts the op
    step("t5_start",  5'b00000, 5'b00000, 0, 1, 4'd5, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    step("t5_busy3",  5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00111, 5'b01000, 5'b00000, 1, 0, 0);
    step("t5_exc",    5'b00000, 5'b00000, 1, 0, 4'd0, 5'b00000, 5'b11111, 5'b11111, 1, 0, 0);
    step("t5_idle",   5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00001, 5'b00000, 0, 0, 1);
    step("t5_rh2",    5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00001, 5'b00000, 0, 0, 1);
    step("t5_clear",  5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
`ifdef PIPELINE_STALL_CTRL_PERF_EN
    perf_chk("perf_kill", 4'd5, 32'd4);
    perf_sel = '0;
    @(posedge clk);
    #1;
`endif
    // reset pulse while busy clears the timer immediately
    step("t6_start",  5'b00000, 5'b00000, 0, 1, 4'd6, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    step("t6_busy",   5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00111, 5'b01000, 5'b00000, 1, 0, 0);
    rst = 1'b1;
    step("t6_reset",  5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b11111, 5'b00000, 0, 0, 0);
    rst = 1'b0;
    step("t6_post1",  5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
    step("t6_post2",  5'b00000, 5'b00000, 0, 0, 4'd0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0);
`ifdef PIPELINE_STALL_CTRL_PERF_EN
    perf_chk("perf_kill_rst", 4'd5, 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
